// File: rtl/pll_reset_gen_pkg.sv
// Shared definitions for the PLL reset generator: FSM encodings and counter width helpers.
package pll_reset_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int          LOSS_CNT_W   = 8;
  localparam logic [7:0]  LOSS_CNT_MAX = 8'hFF;

  // A counter never collapses to zero bits, even when its terminal count is 0.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // Wide enough for the lock-stability count and the whole staggered release span.
  function automatic int cnt_width(input int stable_cycles,
                                   input int num_resets,
                                   input int stagger_cycles);
    int span;
    span = (num_resets - 1) * stagger_cycles + 1;
    return clog2_min1((stable_cycles > span) ? stable_cycles : span);
  endfunction

endpackage

// File: rtl/pll_reset_gen_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit, cleared by a synchronous reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour and the chain shifts by one.
  always_ff @(posedge clk) begin
    if (!reset_) r_chain <= '0;
    else         r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_gen.sv
// Staggered reset-tree generator driven by the PLL lock flag, with drop-out filtering.
// Optional lock_loss_cnt output is built when PLL_RESET_GEN_LOSS_CNT_EN is defined.
module pll_reset_gen
  import pll_reset_gen_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GLITCH_CYCLES  = 4,
  parameter int STAGGER_CYCLES = 16,
  parameter int NUM_RESETS     = 3
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  pll_locked,
  output logic [NUM_RESETS-1:0] rst_out_,
  output logic                  locked_sync,
  output logic                  ready,
  output logic [1:0]            state
`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int CNT_W  = cnt_width(STABLE_CYCLES, NUM_RESETS, STAGGER_CYCLES);
  localparam int LOST_W = clog2_min1(GLITCH_CYCLES + 1);

  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'((NUM_RESETS - 1) * STAGGER_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_LAST    = LOST_W'(GLITCH_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [LOST_W-1:0]     r_lost, w_lost_nxt;
  logic [NUM_RESETS-1:0] r_rst, w_rst_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  w_locked;
  logic                  w_guarded;
  logic                  w_trip;
  logic                  w_stable_done;
  logic                  w_release_done;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_  (reset_),
    .i_async (pll_locked),
    .o_sync  (w_locked)
  );

  assign w_guarded      = (r_state == RELEASE) || (r_state == RUN);
  assign w_trip         = w_guarded && !w_locked && (r_lost == LOST_LAST);
  assign w_stable_done  = (r_state == STABLE) && w_locked && (r_cnt == STABLE_LAST);
  assign w_release_done = (r_state == RELEASE) && (r_cnt == RELEASE_LAST);

  // State, counters and outputs all registered: nothing combinational reaches the ports.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_lost  <= '0;
      r_rst   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lost  <= w_lost_nxt;
      r_rst   <= w_rst_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WAIT_LOCK: if (w_locked) w_state_nxt = STABLE;
      STABLE: begin
        if (!w_locked)          w_state_nxt = WAIT_LOCK;
        else if (w_stable_done) w_state_nxt = (NUM_RESETS == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (w_trip)              w_state_nxt = WAIT_LOCK;
        else if (w_release_done) w_state_nxt = RUN;
      end
      RUN:     if (w_trip) w_state_nxt = WAIT_LOCK;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_lost_nxt  = '0;
    w_rst_nxt   = r_rst;
    w_ready_nxt = r_ready;
    unique case (r_state)
      WAIT_LOCK: begin
        w_cnt_nxt   = '0;
        w_rst_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
      STABLE: begin
        if (!w_locked || w_stable_done) w_cnt_nxt = '0;
        else                            w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_stable_done) begin
          w_rst_nxt[0] = 1'b1;
          w_ready_nxt  = (NUM_RESETS == 1);
        end
      end
      RELEASE, RUN: begin
        if (!w_locked) w_lost_nxt = r_lost + LOST_W'(1);
        if (w_trip) begin
          w_cnt_nxt   = '0;
          w_lost_nxt  = '0;
          w_rst_nxt   = '0;
          w_ready_nxt = 1'b0;
        end else if (r_state == RELEASE) begin
          // Bit i rises i*STAGGER_CYCLES edges after bit 0; short drops do not pause this.
          w_cnt_nxt = w_release_done ? '0 : r_cnt + CNT_W'(1);
          for (int i = 1; i < NUM_RESETS; i++) begin
            if (r_cnt == CNT_W'(i * STAGGER_CYCLES - 1)) w_rst_nxt[i] = 1'b1;
          end
          if (w_release_done) w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_rst_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (!reset_)                                 r_loss_cnt <= '0;
    else if (w_trip && r_loss_cnt != LOSS_CNT_MAX) r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

  assign rst_out_    = r_rst;
  assign ready       = r_ready;
  assign locked_sync = w_locked;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_gen.sv
// Directed, table-driven bench for pll_reset_gen using short timing parameters.
module tb_pll_reset_gen;

  localparam int T_SYNC    = 2;
  localparam int T_STABLE  = 16;
  localparam int T_GLITCH  = 4;
  localparam int T_STAGGER = 8;
  localparam int T_NUM     = 3;

  logic             clk = 1'b0;
  logic             reset_ = 1'b0;
  logic             pll_locked = 1'b0;
  logic [T_NUM-1:0] rst_out_;
  logic             locked_sync;
  logic             ready;
  logic [1:0]       state;
`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  logic [7:0]       lock_loss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  typedef struct {
    int         off;     // edge number relative to E0
    logic       locked;  // pll_locked driven before that edge
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
  } vec_t;

  vec_t rel_tbl[9];

  pll_reset_gen #(
    .SYNC_STAGES    (T_SYNC),
    .STABLE_CYCLES  (T_STABLE),
    .GLITCH_CYCLES  (T_GLITCH),
    .STAGGER_CYCLES (T_STAGGER),
    .NUM_RESETS     (T_NUM)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .pll_locked  (pll_locked),
    .rst_out_    (rst_out_),
    .locked_sync (locked_sync),
    .ready       (ready),
    .state       (state)
`ifdef PLL_RESET_GEN_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] r, input logic rd, input logic [1:0] st);
    check({tag, ".rst_out_"}, 32'(rst_out_), 32'(r));
    check({tag, ".ready"},    32'(ready),    32'(rd));
    check({tag, ".state"},    32'(state),    32'(st));
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (5) tick();
    check_outs("in_reset", 3'b000, 1'b0, 2'd0);
    check("in_reset.locked_sync", 32'(locked_sync), 32'd0);
    reset_  = 1'b1;
    edge_no = 0;
  endtask

  task automatic run_release_table(input int e0);
    for (int i = 0; i < 9; i++) begin
      pll_locked = rel_tbl[i].locked;
      while (edge_no < e0 + rel_tbl[i].off) tick();
      check_outs($sformatf("rel[%0d]", i), rel_tbl[i].rst, rel_tbl[i].rdy, rel_tbl[i].st);
    end
  endtask

`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  task automatic trip_once();
    int k;
    pll_locked = 1'b1;
    k = 0;
    while (rst_out_[0] !== 1'b1 && k < 60) begin tick(); k++; end
    check("trip.reach_release", 32'(rst_out_[0]), 32'd1);
    pll_locked = 1'b0;
    k = 0;
    while (state !== 2'd0 && k < 20) begin tick(); k++; end
    check("trip.reach_wait", 32'(state), 32'd0);
    pll_locked = 1'b1;
  endtask
`endif

  initial begin
    rel_tbl[0] = '{off: -1, locked: 1'b1, rst: 3'b000, rdy: 1'b0, st: 2'd0};
    rel_tbl[1] = '{off:  0, locked: 1'b1, rst: 3'b000, rdy: 1'b0, st: 2'd1};
    rel_tbl[2] = '{off: 15, locked: 1'b1, rst: 3'b000, rdy: 1'b0, st: 2'd1};
    rel_tbl[3] = '{off: 16, locked: 1'b1, rst: 3'b001, rdy: 1'b0, st: 2'd2};
    rel_tbl[4] = '{off: 23, locked: 1'b1, rst: 3'b001, rdy: 1'b0, st: 2'd2};
    rel_tbl[5] = '{off: 24, locked: 1'b1, rst: 3'b011, rdy: 1'b0, st: 2'd2};
    rel_tbl[6] = '{off: 31, locked: 1'b1, rst: 3'b011, rdy: 1'b0, st: 2'd2};
    rel_tbl[7] = '{off: 32, locked: 1'b1, rst: 3'b111, rdy: 1'b1, st: 2'd3};
    rel_tbl[8] = '{off: 40, locked: 1'b1, rst: 3'b111, rdy: 1'b1, st: 2'd3};

    // Power-up with lock present: sync latency, then release at R19/R27/R35.
    pll_locked = 1'b1;
    do_reset();
    tick();
    check("R1.locked_sync", 32'(locked_sync), 32'd0);
    check_outs("R1", 3'b000, 1'b0, 2'd0);
    tick();
    check("R2.locked_sync", 32'(locked_sync), 32'd1);
    run_release_table(3);

    // RUN: a 3-edge drop of locked_sync is filtered.
    for (int k = 0; k < 8; k++) begin
      pll_locked = (k < 3) ? 1'b0 : 1'b1;
      tick();
      check_outs($sformatf("drop3[%0d]", k), 3'b111, 1'b1, 2'd3);
    end

    // RUN: a 4-edge drop trips at the 4th sampled 0, then the sequence repeats.
    begin
      int y;
      y = edge_no;
      for (int k = 0; k < 5; k++) begin
        pll_locked = (k < 4) ? 1'b0 : 1'b1;
        tick();
        check_outs($sformatf("drop4[%0d]", k), 3'b111, 1'b1, 2'd3);
      end
      tick();
      check_outs("drop4.trip", 3'b000, 1'b0, 2'd0);
      run_release_table(y + 7);
    end

    // STABLE: a one-cycle drop at cnt=10 restarts the full stability count.
    pll_locked = 1'b1;
    do_reset();
    while (edge_no < 13) tick();
    check_outs("stab.R13", 3'b000, 1'b0, 2'd1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check_outs("stab.R15", 3'b000, 1'b0, 2'd1);
    tick();
    check_outs("stab.R16", 3'b000, 1'b0, 2'd0);
    run_release_table(17);

    // reset_ during RELEASE clears everything at the next edge.
    pll_locked = 1'b1;
    do_reset();
    while (edge_no < 19) tick();
    check_outs("midrel.R19", 3'b001, 1'b0, 2'd2);
    reset_ = 1'b0;
    tick();
    check_outs("midrel.reset", 3'b000, 1'b0, 2'd0);
    check("midrel.locked_sync", 32'(locked_sync), 32'd0);
    reset_ = 1'b1;

`ifdef PLL_RESET_GEN_LOSS_CNT_EN
    pll_locked = 1'b1;
    do_reset();
    check("loss.after_reset", 32'(lock_loss_cnt), 32'd0);
    repeat (3) trip_once();
    check("loss.3_trips", 32'(lock_loss_cnt), 32'd3);
    repeat (257) trip_once();
    check("loss.260_trips", 32'(lock_loss_cnt), 32'd255);
    do_reset();
    check("loss.cleared", 32'(lock_loss_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
